mac_vector: RTL

Parametrised successor to the single-shot mac: a streaming signed fixed-point dot-product engine.
- After start, accepts len (a, b) sample pairs on a valid/ready handshake and accumulates their products into a wide accumulator.
- Writes a scaled, width-reduced result to dout, flagged by a one-cycle dout_valid pulse.
- Sits behind the DFR reservoir/readout datapath; it serves as the readout weight-times-state multiply-accumulate.

---
 rtl/mac_pkg.sv | 30 +++
 rtl/mac_sat.sv | 35 +++
 rtl/mac_vector.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and constant helpers for the mac_vector
// streaming dot-product engine.
package mac_pkg;

  // Sequencer states of the dot-product engine.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN1 = 2'd2,
    DRAIN2 = 2'd3
  } state_e;

  // Largest signed value representable in 'width' bits (width <= 128),
  // returned zero-extended to 128 bits; size-cast at the use site.
  function automatic logic [127:0] signed_max(input int width);
    return (128'd1 << (width - 1)) - 128'd1;
  endfunction

  // Smallest signed value representable in 'width' bits; its low 'width'
  // bits are 100..0 and it is sign-extended above that.
  function automatic logic [127:0] signed_min(input int width);
    return ~signed_max(width);
  endfunction

  // The accumulator must hold a full product without loss.
  function automatic bit acc_width_ok(input int acc_width, input int data_width);
    return acc_width >= 2 * data_width;
  endfunction

endpackage

// File: rtl/mac_sat.sv
// mac_sat: scales the accumulator by an arithmetic right shift and reduces
// it to the output width, flagging values that do not fit.
// MAC_VECTOR_SATURATE_EN defined: out-of-range values clamp to max/min.
// MAC_VECTOR_SATURATE_EN undefined: the low DATA_WIDTH bits are kept.
module mac_sat
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH  = 64,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 0
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  oor_o
);

  logic signed [ACC_WIDTH-1:0]  shifted;
  logic [ACC_WIDTH-DATA_WIDTH:0] upper;

  assign shifted = $signed(acc_i) >>> FRAC_BITS;
  // The value fits when every bit from the output sign bit upward agrees.
  assign upper   = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
  assign oor_o   = !((&upper) || !(|upper));

`ifdef MAC_VECTOR_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] D_MAX = DATA_WIDTH'(signed_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] D_MIN = DATA_WIDTH'(signed_min(DATA_WIDTH));

  assign res_o = oor_o ? (shifted[ACC_WIDTH-1] ? D_MIN : D_MAX)
                       : shifted[DATA_WIDTH-1:0];
`else
  assign res_o = shifted[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/mac_vector.sv
// mac_vector: streaming signed fixed-point dot-product engine. A start
// latches the vector length; sample pairs are multiplied into a registered
// product that is added into a wide accumulator one cycle later; after the
// pipeline drains the scaled result is written to dout with a dout_valid
// pulse. Optional macro MAC_VECTOR_SATURATE_EN selects clamping (defined)
// or wrapping (undefined) for both the accumulator and dout.
//
// Handshake: a sample pair transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on internal state (never on
// in_valid) and is high only in RUN while count < len.
module mac_vector
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int FRAC_BITS  = 0,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  if (!acc_width_ok(ACC_WIDTH, DATA_WIDTH)) begin : g_width_err
    $error("mac_vector: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end

  localparam int PW = 2 * DATA_WIDTH;

  state_e                       state_q;
  logic [LEN_WIDTH-1:0]         len_q, count_q, count_d;
  logic signed [PW-1:0]         prod_q, prod_d;
  logic                         pend_q;
  logic [ACC_WIDTH-1:0]         acc_q, acc_d;
  logic                         step_q;
  logic [DATA_WIDTH-1:0]        res_q, dout_q;
  logic                         oor_q, dout_valid_q, busy_q, overflow_q;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]         acc_sum;
  logic                         add_ovf;
  logic [DATA_WIDTH-1:0]        sat_res;
  logic                         sat_oor;

  assign prod_d  = $signed(a) * $signed(b);
  assign count_d = count_q + 1'b1;

  // Accumulator adder with signed overflow detection and optional clamp.
  always_comb begin
    prod_ext = ACC_WIDTH'(prod_q);
    acc_sum  = acc_q + prod_ext;
    add_ovf  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
               (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    acc_d    = acc_sum;
`ifdef MAC_VECTOR_SATURATE_EN
    if (add_ovf) begin
      acc_d = acc_q[ACC_WIDTH-1] ? ACC_WIDTH'(signed_min(ACC_WIDTH))
                                 : ACC_WIDTH'(signed_max(ACC_WIDTH));
    end
`endif
  end

  mac_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat (
    .acc_i(acc_q),
    .res_o(sat_res),
    .oor_o(sat_oor)
  );

  // Sequencer, product register, accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      count_q      <= '0;
      prod_q       <= '0;
      pend_q       <= 1'b0;
      acc_q        <= '0;
      step_q       <= 1'b0;
      res_q        <= '0;
      oor_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      // A product registered on the previous edge is added on this one.
      if (pend_q) begin
        acc_q  <= acc_d;
        pend_q <= 1'b0;
        if (add_ovf) overflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= len;
            count_q <= '0;
            step_q  <= 1'b0;
            busy_q  <= 1'b1;
            if (clear) begin
              acc_q      <= '0;
              overflow_q <= 1'b0;
            end
            state_q <= (len == '0) ? DRAIN1 : RUN;
          end else if (clear) begin
            acc_q <= '0;
          end
        end
        RUN: begin
          if (in_valid && in_ready) begin
            prod_q  <= prod_d;
            pend_q  <= 1'b1;
            count_q <= count_d;
            if (count_d == len_q) state_q <= DRAIN1;
          end
        end
        DRAIN1: begin
          // First cycle lets the last product land; second registers the
          // scaled result so the wide shift/range check has a full cycle.
          if (!step_q) begin
            step_q <= 1'b1;
          end else begin
            res_q   <= sat_res;
            oor_q   <= sat_oor;
            state_q <= DRAIN2;
          end
        end
        DRAIN2: begin
          dout_q       <= res_q;
          dout_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          if (oor_q) overflow_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == RUN) && (count_q < len_q);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign dbg_state  = state_q;

endmodule
